// File: rtl/t_ff_bank.sv
// Bank of WIDTH T flip-flops with enable, parallel load, level/edge toggle mode,
// per-bit toggle flags and a saturating activity counter. Define T_FF_BANK_PARITY_EN to add the parity output.
module t_ff_bank #(
   parameter int               WIDTH     = 8,
   parameter int               EDGE_MODE = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] toggled,
   output logic             any_toggle,
`ifdef T_FF_BANK_PARITY_EN
   output logic             parity,
`endif
   output logic [CNT_W-1:0] tcount
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] t_prev;
   logic [WIDTH-1:0] req;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] tog_next;
   logic             any_next;
   logic [CNT_W-1:0] cnt_next;

   // Edge mode only sees rising edges that the history register also observed.
   assign req = (EDGE_MODE != 0) ? (t & ~t_prev) : t;

   always_comb begin
      q_next   = q;
      tog_next = '0;
      if (load) begin
         q_next = d;
      end else if (en) begin
         q_next   = q ^ req;
         tog_next = req;
      end
      any_next = |tog_next;
      cnt_next = tcount;
      if (any_next && (tcount != CNT_MAX)) begin
         cnt_next = tcount + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q          <= RESET_VAL;
         toggled    <= '0;
         any_toggle <= 1'b0;
         tcount     <= '0;
         t_prev     <= t;
      end else begin
         q          <= q_next;
         toggled    <= tog_next;
         any_toggle <= any_next;
         tcount     <= cnt_next;
         t_prev     <= t;
      end
   end

`ifdef T_FF_BANK_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         parity <= ^RESET_VAL;
      end else begin
         parity <= ^q_next;
      end
   end
`endif

endmodule

// File: tb/tb_t_ff_bank.sv
// Directed bench for t_ff_bank: level-mode vector table, plus edge-mode and
// counter-saturation sequences on dedicated instances.
module tb_t_ff_bank;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // level-mode instance
   logic       rst_l, en_l, load_l;
   logic [3:0] d_l, t_l, q_l, tog_l;
   logic       any_l;
   logic [7:0] cnt_l;
   // edge-mode instance
   logic       rst_e, en_e, load_e;
   logic [3:0] d_e, t_e, q_e, tog_e;
   logic       any_e;
   logic [7:0] cnt_e;
   // narrow-counter instance with non-zero reset value
   logic       rst_s, en_s, load_s;
   logic [3:0] d_s, t_s, q_s, tog_s;
   logic       any_s;
   logic [2:0] cnt_s;
`ifdef T_FF_BANK_PARITY_EN
   logic       par_l, par_e, par_s;
`endif

   t_ff_bank #(.WIDTH(4), .EDGE_MODE(0), .RESET_VAL(4'b0000), .CNT_W(8)) u_lvl (
      .clk(clk), .reset(rst_l), .en(en_l), .load(load_l), .d(d_l), .t(t_l),
      .q(q_l), .toggled(tog_l), .any_toggle(any_l),
`ifdef T_FF_BANK_PARITY_EN
      .parity(par_l),
`endif
      .tcount(cnt_l));

   t_ff_bank #(.WIDTH(4), .EDGE_MODE(1), .RESET_VAL(4'b0000), .CNT_W(8)) u_edge (
      .clk(clk), .reset(rst_e), .en(en_e), .load(load_e), .d(d_e), .t(t_e),
      .q(q_e), .toggled(tog_e), .any_toggle(any_e),
`ifdef T_FF_BANK_PARITY_EN
      .parity(par_e),
`endif
      .tcount(cnt_e));

   t_ff_bank #(.WIDTH(4), .EDGE_MODE(0), .RESET_VAL(4'b0111), .CNT_W(3)) u_sat (
      .clk(clk), .reset(rst_s), .en(en_s), .load(load_s), .d(d_s), .t(t_s),
      .q(q_s), .toggled(tog_s), .any_toggle(any_s),
`ifdef T_FF_BANK_PARITY_EN
      .parity(par_s),
`endif
      .tcount(cnt_s));

   typedef struct {
      logic       rst;
      logic       en;
      logic       load;
      logic [3:0] d;
      logic [3:0] t;
      logic [3:0] q;
      logic [3:0] tog;
      logic       any;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_edge(input int idx, input logic [3:0] eq, input logic [3:0] etog,
                           input logic [7:0] ecnt);
      chk("edge_q", idx, 32'(q_e), 32'(eq));
      chk("edge_tog", idx, 32'(tog_e), 32'(etog));
      chk("edge_any", idx, 32'(any_e), 32'(|etog));
      chk("edge_cnt", idx, 32'(cnt_e), 32'(ecnt));
`ifdef T_FF_BANK_PARITY_EN
      chk("edge_par", idx, 32'(par_e), 32'(^eq));
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] sq;
      logic [2:0] scnt;

      //        rst  en   load d      t      q      tog    any  cnt
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 8'd0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 8'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 8'd1};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 8'd0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 4'h5, 4'h5, 1'b1, 8'd1};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 4'h0, 4'h5, 1'b1, 8'd2};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 4'h5, 4'h5, 1'b1, 8'd3};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 4'h0, 4'h5, 1'b1, 8'd4};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 8'd4};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'd4};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 8'd5};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 4'hA, 4'hF, 4'hA, 4'h0, 1'b0, 8'd5};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h3, 4'h9, 4'h3, 1'b1, 8'd6};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 4'h6, 4'hF, 4'h6, 4'h0, 1'b0, 8'd6};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 8'd0};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 4'h8, 4'h8, 1'b1, 8'd1};

      rst_l = 1'b1; en_l = 1'b1; load_l = 1'b0; d_l = 4'h0; t_l = 4'hF;
      rst_e = 1'b1; en_e = 1'b1; load_e = 1'b0; d_e = 4'h0; t_e = 4'hF;
      rst_s = 1'b1; en_s = 1'b1; load_s = 1'b0; d_s = 4'h0; t_s = 4'h1;

      // Level-mode table
      for (int i = 0; i < 16; i++) begin
         rst_l  = vecs[i].rst;
         en_l   = vecs[i].en;
         load_l = vecs[i].load;
         d_l    = vecs[i].d;
         t_l    = vecs[i].t;
         step();
         chk("lvl_q", i, 32'(q_l), 32'(vecs[i].q));
         chk("lvl_tog", i, 32'(tog_l), 32'(vecs[i].tog));
         chk("lvl_any", i, 32'(any_l), 32'(vecs[i].any));
         chk("lvl_cnt", i, 32'(cnt_l), 32'(vecs[i].cnt));
`ifdef T_FF_BANK_PARITY_EN
         chk("lvl_par", i, 32'(par_l), 32'(^vecs[i].q));
`endif
      end

      // Edge mode: t high through reset, then release -> no toggle
      rst_e = 1'b1; t_e = 4'hF; en_e = 1'b1;
      step(); chk_edge(0, 4'h0, 4'h0, 8'd0);
      step(); chk_edge(1, 4'h0, 4'h0, 8'd0);
      rst_e = 1'b0;
      step(); chk_edge(2, 4'h0, 4'h0, 8'd0);
      t_e = 4'h0;
      step(); chk_edge(3, 4'h0, 4'h0, 8'd0);
      // t[0] rises and stays high: exactly one toggle
      t_e = 4'h1;
      step(); chk_edge(4, 4'h1, 4'h1, 8'd1);
      for (int k = 0; k < 4; k++) begin
         step(); chk_edge(5 + k, 4'h1, 4'h0, 8'd1);
      end
      // t[2] rises while disabled: edge lost
      en_e = 1'b0; t_e = 4'h5;
      step(); chk_edge(9, 4'h1, 4'h0, 8'd1);
      en_e = 1'b1;
      step(); chk_edge(10, 4'h1, 4'h0, 8'd1);
      // Rising edge coinciding with load is consumed
      t_e = 4'h0;
      step(); chk_edge(11, 4'h1, 4'h0, 8'd1);
      load_e = 1'b1; d_e = 4'h0; t_e = 4'h8;
      step(); chk_edge(12, 4'h0, 4'h0, 8'd1);
      load_e = 1'b0;
      step(); chk_edge(13, 4'h0, 4'h0, 8'd1);
      t_e = 4'h0;
      step(); chk_edge(14, 4'h0, 4'h0, 8'd1);
      t_e = 4'h8;
      step(); chk_edge(15, 4'h8, 4'h8, 8'd2);

      // Saturating 3-bit counter, level mode, RESET_VAL=0111
      rst_s = 1'b1; t_s = 4'h1; en_s = 1'b1;
      step();
      chk("sat_q", 0, 32'(q_s), 32'(4'h7));
      chk("sat_cnt", 0, 32'(cnt_s), 32'(3'd0));
`ifdef T_FF_BANK_PARITY_EN
      chk("sat_par", 0, 32'(par_s), 32'(1'b1));
`endif
      rst_s = 1'b0;
      sq = 4'h7;
      scnt = 3'd0;
      for (int k = 1; k <= 10; k++) begin
         step();
         sq = sq ^ 4'h1;
         if (scnt != 3'd7) scnt = scnt + 3'd1;
         chk("sat_q", k, 32'(q_s), 32'(sq));
         chk("sat_tog", k, 32'(tog_s), 32'(4'h1));
         chk("sat_cnt", k, 32'(cnt_s), 32'(scnt));
`ifdef T_FF_BANK_PARITY_EN
         chk("sat_par", k, 32'(par_s), 32'(^sq));
`endif
      end
      chk("sat_hold", 11, 32'(cnt_s), 32'(3'd7));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
